// File: rtl/divider_pkg.sv
// Shared types and the floored sign-correction used by the sequential divider
// and by reference models that need the same result rules.
package divider_pkg;

    // Widest operand the shared correction function handles.
    localparam int MAXW = 64;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    typedef struct packed {
        logic [MAXW-1:0] quot;
        logic [MAXW-1:0] rem;
    } result_t;

    // Turns the magnitude result (q0, r0) into floored quotient/remainder.
    // Arithmetic is modulo 2^MAXW; callers keep the low W bits, which is exact.
    function automatic result_t floor_fix(
        input logic [MAXW-1:0] q0,
        input logic [MAXW-1:0] r0,
        input logic [MAXW-1:0] b,
        input logic            sx,
        input logic            sy
    );
        result_t res;
        if (sx == sy) begin
            res.quot = q0;
            res.rem  = sy ? -r0 : r0;
        end else if (r0 == '0) begin
            res.quot = -q0;
            res.rem  = '0;
        end else begin
            res.quot = ~q0;
            res.rem  = sy ? (r0 - b) : (b - r0);
        end
        return res;
    endfunction

endpackage

// File: rtl/divider_if.sv
// Start/busy/done handshake and operand/result bundle of the sequential divider.
interface divider_if #(
    parameter int W = 32
);
    logic         start;
    logic         u;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         dz;
    logic         ovf;

    modport master (
        output start, u, x, y,
        input  busy, done, quot, rem, dz, ovf
    );

    modport slave (
        input  start, u, x, y,
        output busy, done, quot, rem, dz, ovf
    );
endinterface

// File: rtl/divider_step.sv
// One restoring division step over the packed {remainder, quotient} register.
module divider_step #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] acc_next
);
    // Shifted partial remainder needs W+1 bits: 2*r+bit can exceed 2^W-1.
    logic [W:0]   trial;
    logic [W+1:0] diff;
    logic         borrow;

    assign trial    = acc[2*W-1:W-1];
    assign diff     = {1'b0, trial} - {2'b00, b};
    assign borrow   = diff[W+1];
    assign acc_next = {(borrow ? trial[W-1:0] : diff[W-1:0]), acc[W-2:0], ~borrow};
endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, floored signed or
// unsigned, with divide-by-zero and overflow flags and held results.
module divider_seq
    import divider_pkg::*;
#(
    parameter int W = 32   // 2 <= W <= MAXW
) (
    input logic      clk,
    input logic      rst,
    divider_if.slave bus
);
    localparam logic [W-1:0] LAST = W'(W - 1);
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    state_t         state_reg;
    logic           sx_reg, sy_reg;
    logic           dz_pend_reg, ovf_pend_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] acc_reg;
    logic [W-1:0]   cnt_reg;
    logic [W-1:0]   xraw_reg;
    logic           busy_reg, done_reg, dz_reg, ovf_reg;
    logic [W-1:0]   quot_reg, rem_reg;

    logic           sx_in, sy_in;
    logic [W-1:0]   a_abs, b_abs;
    logic [2*W-1:0] acc_next;
    logic [2*W-1:0] fix_w;

    function automatic logic [2*W-1:0] fix_trunc(input logic [2*W-1:0] acc,
                                                 input logic [W-1:0] b,
                                                 input logic sx, input logic sy);
        result_t res;
        res = floor_fix(MAXW'(acc[W-1:0]), MAXW'(acc[2*W-1:W]), MAXW'(b), sx, sy);
        return {res.quot[W-1:0], res.rem[W-1:0]};
    endfunction

    assign sx_in = bus.u & bus.x[W-1];
    assign sy_in = bus.u & bus.y[W-1];
    assign a_abs = sx_in ? -bus.x : bus.x;
    assign b_abs = sy_in ? -bus.y : bus.y;
    assign fix_w = fix_trunc(acc_reg, b_reg, sx_reg, sy_reg);

    divider_step #(.W(W)) u_step (
        .acc      (acc_reg),
        .b        (b_reg),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            sx_reg       <= 1'b0;
            sy_reg       <= 1'b0;
            dz_pend_reg  <= 1'b0;
            ovf_pend_reg <= 1'b0;
            b_reg        <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            xraw_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            dz_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
            quot_reg     <= '0;
            rem_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        sx_reg       <= sx_in;
                        sy_reg       <= sy_in;
                        b_reg        <= b_abs;
                        acc_reg      <= {{W{1'b0}}, a_abs};
                        cnt_reg      <= '0;
                        xraw_reg     <= bus.x;
                        dz_pend_reg  <= (bus.y == '0);
                        ovf_pend_reg <= bus.u & (bus.x == MINV) & (bus.y == '1);
                        busy_reg     <= 1'b1;
                        state_reg    <= DIV;
                    end
                end
                DIV: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + W'(1);
                    if (cnt_reg == LAST) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    // Divide-by-zero returns all ones and the untouched dividend.
                    if (dz_pend_reg) begin
                        quot_reg <= '1;
                        rem_reg  <= xraw_reg;
                    end else begin
                        quot_reg <= fix_w[2*W-1:W];
                        rem_reg  <= fix_w[W-1:0];
                    end
                    dz_reg    <= dz_pend_reg;
                    ovf_reg   <= ovf_pend_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.quot = quot_reg;
    assign bus.rem  = rem_reg;
    assign bus.dz   = dz_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_divider_seq.sv
// Randomised self-checking bench for divider_seq at W=32 and W=8 against an
// arithmetic floored-division model.
module tb_divider_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, u, sel8;
    logic [63:0] x, y;

    always #5 clk = ~clk;

    divider_if #(.W(32)) b32 ();
    divider_if #(.W(8))  b8 ();

    assign b32.start = start & ~sel8;
    assign b8.start  = start & sel8;
    assign b32.u     = u;
    assign b8.u      = u;
    assign b32.x     = x[31:0];
    assign b8.x      = x[7:0];
    assign b32.y     = y[31:0];
    assign b8.y      = y[7:0];

    divider_seq #(.W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    divider_seq #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    logic [63:0] cur_quot, cur_rem;
    logic        cur_busy, cur_done, cur_dz, cur_ovf;

    always_comb begin
        if (sel8) begin
            cur_quot = 64'(b8.quot);
            cur_rem  = 64'(b8.rem);
            cur_busy = b8.busy;
            cur_done = b8.done;
            cur_dz   = b8.dz;
            cur_ovf  = b8.ovf;
        end else begin
            cur_quot = 64'(b32.quot);
            cur_rem  = 64'(b32.rem);
            cur_busy = b32.busy;
            cur_done = b32.done;
            cur_dz   = b32.dz;
            cur_ovf  = b32.ovf;
        end
    end

    int          n_checks = 0;
    int          n_err = 0;
    logic [63:0] prev_q, prev_r;
    bit          have_prev = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Floored division from plain signed arithmetic: truncate, then move the
    // quotient down by one when the remainder's sign disagrees with y.
    task automatic model(input int w, input bit uu, input logic [63:0] xi, input logic [63:0] yi,
                         output logic [63:0] q, output logic [63:0] r,
                         output bit dzo, output bit ovo);
        longint mask, xs, ys, qq, rr;
        mask = (longint'(1) << w) - 1;
        xs   = longint'(xi) & mask;
        ys   = longint'(yi) & mask;
        if (uu && ((xs >> (w - 1)) & 1) != 0) xs = xs - (longint'(1) << w);
        if (uu && ((ys >> (w - 1)) & 1) != 0) ys = ys - (longint'(1) << w);
        dzo = 0;
        ovo = 0;
        if (ys == 0) begin
            q   = 64'(mask);
            r   = 64'(longint'(xi) & mask);
            dzo = 1;
        end else if (uu && xs == -(longint'(1) << (w - 1)) && ys == -1) begin
            q   = 64'(longint'(1) << (w - 1));
            r   = 0;
            ovo = 1;
        end else begin
            qq = xs / ys;
            rr = xs % ys;
            if (rr != 0 && ((rr < 0) != (ys < 0))) begin
                qq = qq - 1;
                rr = rr + ys;
            end
            q = 64'(qq & mask);
            r = 64'(rr & mask);
        end
    endtask

    // Issues start immediately (so a call right after done is back-to-back),
    // optionally pulses start again while busy, and checks the whole operation.
    task automatic run_op(input bit u_i, input logic [63:0] x_i, input logic [63:0] y_i,
                          input int pulse_at);
        logic [63:0] eq, er;
        bit          edz, eovf;
        int          w, lat, busy_n;
        w = sel8 ? 8 : 32;
        model(w, u_i, x_i, y_i, eq, er, edz, eovf);
        u = u_i; x = x_i; y = y_i; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        u = 1'($urandom); x = {$urandom, $urandom}; y = {$urandom, $urandom};
        lat = 0;
        busy_n = 0;
        while (!cur_done && lat <= 2 * w + 8) begin
            if (cur_busy) busy_n++;
            if (have_prev) begin
                check("hold_quot", cur_quot, prev_q);
                check("hold_rem", cur_rem, prev_r);
            end
            if (lat == pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        check("latency", 64'(lat), 64'(w + 1));
        check("busy_cycles", 64'(busy_n), 64'(w + 1));
        check("busy_at_done", 64'(cur_busy), 64'(0));
        check("quot", cur_quot, eq);
        check("rem", cur_rem, er);
        check("dz", 64'(cur_dz), 64'(edz));
        check("ovf", 64'(cur_ovf), 64'(eovf));
        $display("op w=%0d u=%0d x=%h y=%h -> quot=%h rem=%h dz=%0d ovf=%0d lat=%0d",
                 w, u_i, x_i & ((64'd1 << w) - 1), y_i & ((64'd1 << w) - 1),
                 cur_quot, cur_rem, cur_dz, cur_ovf, lat);
        prev_q = eq;
        prev_r = er;
        have_prev = 1;
    endtask

    int tx[4] = '{7, -7, -7, -8};
    int ty[4] = '{-2, 2, -2, 2};
    int tq[4] = '{-4, -4, 3, -4};
    int tr[4] = '{-1, 1, -1, 0};
    logic [7:0] bx[5] = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd255};
    logic [7:0] by[6] = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd255};

    initial begin
        rst = 1'b0; start = 1'b0; sel8 = 1'b0; u = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(cur_busy), 64'(0));
        check("rst_done", 64'(cur_done), 64'(0));
        check("rst_quot", cur_quot, 64'(0));
        check("rst_rem", cur_rem, 64'(0));
        check("rst_dz", 64'(cur_dz), 64'(0));
        check("rst_ovf", 64'(cur_ovf), 64'(0));
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // Unsigned example, then done must drop after one cycle
        run_op(1'b0, 64'd100, 64'd7, -1);
        check("ex_quot", cur_quot, 64'd14);
        check("ex_rem", cur_rem, 64'd2);
        @(posedge clk); #1;
        check("done_pulse", 64'(cur_done), 64'(0));

        // Sign combinations; the first one also gets a start pulse while busy
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 64'(tx[i]), 64'(ty[i]), (i == 0) ? 10 : -1);
            check("sgn_quot", cur_quot, {32'h0, tq[i]});
            check("sgn_rem", cur_rem, {32'h0, tr[i]});
        end

        // Overflow, divide-by-zero, then a plain divide clearing both flags
        run_op(1'b1, 64'h8000_0000, 64'hFFFF_FFFF, -1);
        check("ovf_quot", cur_quot, 64'h8000_0000);
        check("ovf_flag", 64'(cur_ovf), 64'(1));
        run_op(1'b0, 64'h1234, 64'h0, -1);
        check("dz_quot", cur_quot, 64'hFFFF_FFFF);
        check("dz_rem", cur_rem, 64'h1234);
        run_op(1'b1, 64'd50, 64'd5, -1);
        check("clr_dz", 64'(cur_dz), 64'(0));
        check("clr_ovf", 64'(cur_ovf), 64'(0));

        // Random W=32 traffic with idle gaps
        for (int i = 0; i < 40; i++) begin
            logic [63:0] rx, ry;
            rx = 64'($urandom);
            ry = (i % 4 == 0) ? 64'($urandom_range(0, 20)) : 64'($urandom >> $urandom_range(0, 31));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op(1'(i % 2), rx, ry, -1);
        end

        // Reset in the middle of an operation
        u = 1'b1; x = 64'hFFFF_F000; y = 64'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", 64'(cur_busy), 64'(0));
        check("arst_done", 64'(cur_done), 64'(0));
        check("arst_quot", cur_quot, 64'(0));
        check("arst_rem", cur_rem, 64'(0));
        check("arst_dz", 64'(cur_dz), 64'(0));
        check("arst_ovf", 64'(cur_ovf), 64'(0));
        repeat (3) begin
            @(posedge clk); #1;
            check("arst_no_done", 64'(cur_done), 64'(0));
        end
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        have_prev = 0;
        run_op(1'b1, 64'hFFFF_FFF9, 64'd2, -1);

        // W=8: boundary grid in both modes, then random coverage
        sel8 = 1'b1;
        have_prev = 0;
        @(negedge clk);
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 6; j++)
                    run_op(1'(m), 64'(bx[i]), 64'(by[j]), -1);
        for (int i = 0; i < 600; i++)
            run_op(1'($urandom), 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/divider_seq.md
# divider_seq

Parametrised sequential integer divider: the next generation of the RISC5 restoring divider. It is generalised to width W and adds the following:
- fully signed floored division, with both operands signed;
- a start/busy/done handshake in place of the run/stall interface;
- divide-by-zero and overflow flags;
- results held until the next operation.

It sits beside the multiplier in the execute stage and serves DIV/MOD. It retires one quotient bit per clock, restoring style.

## Interface
- W, 32: operand and result width, W ≥ 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only when busy=0.
- u  in  1  1 = signed (two's complement) operands, 0 = unsigned. Captured with start.
- x  in  W  dividend. Captured with start.
- y  in  W  divisor. Captured with start.
- busy  out  1  operation in progress; start is ignored while high.
- done  out  1  one-cycle pulse when quot/rem/dz/ovf are updated.
- quot  out  W  quotient, held until the next done.
- rem  out  W  remainder, held until the next done.
- dz  out  1  last operation had y=0. Held.
- ovf  out  1  last operation was signed −2^(W−1) / −1. Held.

## Operation
- **State machine:** IDLE → DIV → FIX → IDLE.
  - IDLE, start=1: latch the inputs and move to DIV. The latched values are u, sign(x)=x[W−1]&u, sign(y)=y[W−1]&u, a=|x|, b=|y|, a W-bit unsigned iteration counter cleared to 0, and a raw copy of x for the dz case.
  - DIV: one restoring step per cycle over the 2W-bit remainder/quotient register. Shift in the next dividend bit, trial-subtract b, keep the difference if it is non-negative, and shift in ~borrow. After exactly W steps go to FIX.
  - FIX: the register holds q0=a/b and r0=a mod b. Write the outputs, pulse done, return to IDLE.
- **Result rules:**
  - Unsigned: quot=q0, rem=r0.
  - Signed, signs equal: quot=q0; rem = y<0 ? −r0 : r0.
  - Signed, signs differ, r0=0: quot=−q0, rem=0.
  - Signed, signs differ, r0≠0: quot=−q0−1; rem = y<0 ? −(b−r0) : b−r0.
  - These rules give floored division: rem is 0 or has the sign of y, and x = quot·y + rem.
- **Width:** all arithmetic is modulo 2^W. |−2^(W−1)| = 2^(W−1) fits as unsigned, so no extra bit is needed.
- **Divide by zero (y=0):** the iteration still runs for the full latency. FIX overrides the result: quot = all ones, rem = raw x, dz=1, ovf=0.
- **Overflow (u=1, x=−2^(W−1), y=−1):** quot = −2^(W−1) (natural wrap), rem=0, ovf=1.
- **Flags:** dz and ovf are written on every done, so each one is cleared by the next operation that does not trigger it.

## Timing
- **Reset values:** rst low clears immediately, regardless of clock: state=IDLE, busy=0, done=0, quot=0, rem=0, dz=0, ovf=0, counter=0. A rst assertion mid-operation aborts it; no done is produced.
- **Start accepted at edge E0:** busy=1 after E0.
- **Division steps:** E1…EW.
- **FIX at E(W+1):** done=1, busy=0 and new results are visible after E(W+1). Latency is W+1 cycles, independent of operand values.
- **done:** high for exactly one cycle.
- **Back-to-back:** start is accepted in the same cycle done=1, because busy=0 then. Throughput is one operation per W+1 cycles.
- **Start while busy:** ignored, with no effect on the operation in flight.
- **Input hold:** inputs need not be held after E0.

## Structure
- **Package divider_pkg:**
  - state enum IDLE/DIV/FIX;
  - a function for the floored sign correction (q0, r0, b, sign bits) → {quot, rem}, shared with the multiplier bench's reference model.
- **One sub-module, divider_step:** combinational, W-bit. It takes the 2W-bit register and b and returns the next register value. It keeps the iteration datapath separate from the control and allows a later radix-4 variant to instantiate two steps.

## Test plan
- **Unsigned, W=32:** u=0, x=100, y=7 → quot=14, rem=2; done exactly 33 cycles after start; busy high for 33 cycles.
- **Signed sign combinations, W=32:**
  - x=7, y=−2 → quot=−4, rem=−1;
  - x=−7, y=2 → quot=−4, rem=1;
  - x=−7, y=−2 → quot=3, rem=−1;
  - x=−8, y=2 → quot=−4, rem=0.
- **Corner values, W=32:**
  - u=1, x=0x80000000, y=0xFFFFFFFF → quot=0x80000000, rem=0, ovf=1;
  - y=0, x=0x1234 → quot=0xFFFFFFFF, rem=0x1234, dz=1;
  - the next valid divide clears dz and ovf.
- **Handshake, W=32:**
  - start pulsed at cycle 10 while busy → ignored, result unchanged;
  - start asserted in the done cycle → second op accepted;
  - results held stable between the two dones.
- **Reset, W=32:** rst asserted at step 15 → all outputs 0 immediately, no done. A new op after release gives correct results.
- **Width W=8, exhaustive:** all x, y in both modes against the package reference function; latency 9 cycles.
